step_move_sequencer: RTL and testbench
======================================

Name: step_move_sequencer

Overview:
- Offloads relative-move instructions (full-step and half-step moves) from the processor control FSM.
- Accepts a signed relative step count, then steps the motor one unit at a time with a programmable inter-step delay.
- Updates the absolute position and drives the 4-bit coil pattern.
- Sits between the control FSM (command/done handshake) and the stepper coil outputs; it owns the inter-step delay counter.

Parameters:
- POS_W, 8, width of signed position and relative command
- DELAY_W, 20, width of inter-step delay count

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  move request
- cmd_ready  out  1  high when a command can be accepted
- cmd_rel  in  POS_W  signed relative step count
- cmd_half  in  1  1 = half-step mode, 0 = full-step mode
- delay_cycles  in  DELAY_W  inter-step wait length in cycles
- abort  in  1  cancel the current move
- busy  out  1  move in progress
- done  out  1  one-cycle pulse when a move completes
- step_pulse  out  1  high for the cycle in which a step is taken
- position  out  POS_W  signed absolute position in step units
- phase  out  3  half-step phase index
- coils  out  4  coil drive pattern

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: state IDLE, position 0, phase 0, coils 4'b1000, remaining 0, busy 0, done 0, step_pulse 0, cmd_ready 1.
- States: IDLE, STEP, WAIT, DONE.
- Decoded outputs:
  - cmd_ready = (state==IDLE).
  - busy = (state==STEP or WAIT).
  - step_pulse = (state==STEP).
  - done = (state==DONE).
- IDLE:
  - A command is accepted when cmd_valid && cmd_ready.
  - On accept, latch dir = sign(cmd_rel), remaining = |cmd_rel| as unsigned POS_W. -2^(POS_W-1) gives magnitude 2^(POS_W-1), which fits.
  - On accept, also latch the mode and wait = max(delay_cycles,1).
  - If remaining==0, next state is DONE; otherwise STEP.
- STEP (exactly 1 cycle):
  - position += dir (±1), wrapping modulo 2^POS_W.
  - phase += dir in half-step mode or += 2*dir in full-step mode, modulo 8. Full-step mode preserves phase parity.
  - remaining -= 1.
  - Load the delay counter with the latched wait; next state WAIT.
- WAIT:
  - Counter decrements each cycle and lasts exactly `wait` cycles.
  - On expiry: if remaining==0, go to DONE; otherwise go to STEP.
- DONE: one cycle, then IDLE.
- Timing: for command accepted at cycle T with n>0 steps and wait w:
  - step_pulse at T+1+k(w+1), for k=0..n-1.
  - done at T+1+n(w+1).
  - For n=0, done at T+1.
- coils: registered, derived from phase. Phase 0..7 → 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. The pattern holds (energised) when idle.
- position, phase and coils change only at the end of a STEP cycle; new values are visible the cycle after step_pulse.
- abort:
  - In STEP, WAIT or DONE: next state IDLE, remaining cleared, no done pulse.
  - position/phase keep their current values. A STEP cycle coincident with abort still completes its update.
  - abort in IDLE has no effect. If abort and cmd_valid arrive together in IDLE, abort has priority: no accept.
- cmd_valid while not ready is ignored (not queued). delay_cycles and cmd_half changes mid-move have no effect.
- Asynchronous reset mid-move: all outputs return to reset values immediately, and the move is discarded.

Decomposition:
- Shared package step_pkg:
  - state enumeration.
  - 8-entry half-step coil table constant.
  - direction encoding.
- Sub-module step_delay_timer:
  - load/value inputs, expired output, DELAY_W-bit down-counter.
  - Same reset rules.

Test Plan:
1. Reset; cmd_rel=+3, full-step, delay=4 accepted at T → step_pulse at T+1, T+6, T+11; position 3; phase 2,4,6; coils 0100, 0010, 0001; done at T+16; cmd_ready at T+17.
2. From reset: cmd_rel=-2, half-step, delay=0 → wait clamps to 1; pulses at T+1, T+3; position 0xFE; phase 7 then 6; coils 1001 then 0001; done at T+5.
3. cmd_rel=0 → no step_pulse; done at T+1; position unchanged.
4. POS_W=8, cmd_rel=-128 (0x80), delay=1 from position 0 → exactly 128 pulses; position 0x80; done at T+1+128*2.
5. cmd_rel=+5, abort during 2nd WAIT → IDLE next cycle, position 2, no done. cmd_valid during busy is ignored; a fresh command afterwards behaves as in scenario 1.
6. Assert reset asynchronously mid-WAIT (between edges) → position 0, coils 1000, busy 0, cmd_ready 1 before the next clock edge.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types and constants for the relative-move stepper sequencer.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } step_state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } step_dir_t;

  // Half-step coil patterns; entry 0 sits in the least significant nibble.
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [2:0] phase_advance(input logic [2:0] phase,
                                               input step_dir_t dir,
                                               input logic half);
    logic [2:0] inc;
    inc = half ? 3'd1 : 3'd2;
    return (dir == DIR_NEG) ? phase - inc : phase + inc;
  endfunction

endpackage

// File: rtl/step_delay_timer.sv
// Inter-step delay down-counter; expired flags the last cycle of a loaded wait.
module step_delay_timer #(
  parameter int DELAY_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DELAY_W-1:0] value,
  output logic               expired
);

  logic [DELAY_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load of w gives exactly w following cycles, the last one with count==1.
  assign expired = (count == DELAY_W'(1));

endmodule

// File: rtl/step_move_sequencer.sv
// Relative-move sequencer: steps the motor one unit at a time with a
// programmable inter-step delay, tracking absolute position and coil pattern.
module step_move_sequencer
  import step_pkg::*;
#(
  parameter int POS_W   = 8,
  parameter int DELAY_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [POS_W-1:0] cmd_rel,
  input  logic                    cmd_half,
  input  logic [DELAY_W-1:0]      delay_cycles,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    step_pulse,
  output logic signed [POS_W-1:0] position,
  output logic [2:0]              phase,
  output logic [3:0]              coils
);

  step_state_t        state, state_nxt;
  step_dir_t          dir_q;
  logic               half_q;
  logic [DELAY_W-1:0] wait_q;
  logic [POS_W-1:0]   remaining;
  logic [POS_W-1:0]   magnitude;
  logic [2:0]         phase_nxt;
  logic               accept;
  logic               load_timer;
  logic               timer_expired;

  assign accept    = (state == ST_IDLE) && cmd_valid && !abort;
  // Two's-complement negate; the most negative command maps to 2^(POS_W-1).
  assign magnitude = cmd_rel[POS_W-1] ? (~cmd_rel + 1'b1) : cmd_rel;
  assign phase_nxt = phase_advance(phase, dir_q, half_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_timer = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (cmd_rel == '0) ? ST_DONE : ST_STEP;
        end
      end
      ST_STEP: begin
        load_timer = 1'b1;
        state_nxt  = abort ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (timer_expired) begin
          state_nxt = (remaining == '0) ? ST_DONE : ST_STEP;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q     <= DIR_POS;
      half_q    <= 1'b0;
      wait_q    <= DELAY_W'(1);
      remaining <= '0;
    end else if (accept) begin
      dir_q     <= cmd_rel[POS_W-1] ? DIR_NEG : DIR_POS;
      half_q    <= cmd_half;
      wait_q    <= (delay_cycles == '0) ? DELAY_W'(1) : delay_cycles;
      remaining <= magnitude;
    end else if (abort && (state != ST_IDLE)) begin
      remaining <= '0;
    end else if (state == ST_STEP) begin
      remaining <= remaining - 1'b1;
    end
  end

  // Position/phase updates complete even when abort lands on a STEP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position <= '0;
      phase    <= 3'd0;
      coils    <= 4'b1000;
    end else if (state == ST_STEP) begin
      position <= (dir_q == DIR_NEG) ? position - 1'b1 : position + 1'b1;
      phase    <= phase_nxt;
      coils    <= COIL_TABLE[phase_nxt];
    end
  end

  step_delay_timer #(
    .DELAY_W(DELAY_W)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .load    (load_timer),
    .value   (wait_q),
    .expired (timer_expired)
  );

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state == ST_STEP) || (state == ST_WAIT);
  assign step_pulse = (state == ST_STEP);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_step_move_sequencer.sv
// Self-checking bench for step_move_sequencer: vector table, random moves
// against an arithmetic reference model, and hand-written abort/reset cases.
module tb_step_move_sequencer;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [7:0] cmd_rel;
  logic              cmd_half;
  logic [19:0]       delay_cycles;
  logic              abort;
  logic              busy;
  logic              done;
  logic              step_pulse;
  logic signed [7:0] position;
  logic [2:0]        phase;
  logic [3:0]        coils;

  int checks   = 0;
  int failures = 0;
  int m_pos    = 0;
  int m_phase  = 0;
  logic [3:0] tb_coil [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                              4'b0010, 4'b0011, 4'b0001, 4'b1001};

  typedef struct {
    int         rel;
    bit         half;
    int         dly;
    int         exp_pos;
    int         exp_phase;
    logic [3:0] exp_coils;
    int         exp_done;
  } vec_t;
  vec_t vecs [6];

  step_move_sequencer #(.POS_W(8), .DELAY_W(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rel      (cmd_rel),
    .cmd_half     (cmd_half),
    .delay_cycles (delay_cycles),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .step_pulse   (step_pulse),
    .position     (position),
    .phase        (phase),
    .coils        (coils)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_rel = '0; cmd_half = 1'b0; delay_cycles = '0; abort = 1'b0;
    tick();
    reset = 1'b0;
    m_pos = 0;
    m_phase = 0;
  endtask

  task automatic check_pos_model(input string tag);
    chk({tag, "_position"}, 32'($unsigned(position)), 32'(m_pos));
    chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
    chk({tag, "_coils"}, 32'(coils), 32'(tb_coil[m_phase]));
  endtask

  // Issues a move from the current negedge (cycle T) and checks every cycle
  // up to one past the expected done pulse against the reference model.
  task automatic run_cmd(input int rel, input bit half, input int dly,
                         input bit noise, output int done_seen);
    int w, n, dir, exp_done;
    bit exp_pulse;
    w = (dly == 0) ? 1 : dly;
    n = (rel < 0) ? -rel : rel;
    dir = (rel < 0) ? -1 : 1;
    exp_done = (n == 0) ? 1 : 1 + n * (w + 1);
    cmd_rel = rel[7:0]; cmd_half = half; delay_cycles = dly[19:0]; cmd_valid = 1'b1;
    done_seen = -1;
    for (int c = 1; c <= exp_done + 1; c++) begin
      tick();
      exp_pulse = (n > 0) && (c < exp_done) && ((c - 1) % (w + 1) == 0);
      if (c <= exp_done) begin
        chk("step_pulse", 32'(step_pulse), 32'(exp_pulse));
        chk("done", 32'(done), 32'(c == exp_done));
        chk("busy", 32'(busy), 32'(c < exp_done));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      end else begin
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("done_after", 32'(done), 32'd0);
      end
      check_pos_model("move");
      if (done && done_seen < 0) done_seen = c;
      if (exp_pulse) begin
        m_pos = (m_pos + dir + 256) % 256;
        m_phase = (m_phase + dir * (half ? 1 : 2) + 8) % 8;
      end
      if (noise && c < exp_done) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_rel = 8'($urandom);
        cmd_half = 1'($urandom_range(0, 1));
        delay_cycles = 20'($urandom_range(0, 9));
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int ds;
    int rel;

    vecs[0] = '{rel:  3,   half: 0, dly: 4, exp_pos: 3,   exp_phase: 6, exp_coils: 4'b0001, exp_done: 16};
    vecs[1] = '{rel: -2,   half: 1, dly: 0, exp_pos: 254, exp_phase: 6, exp_coils: 4'b0001, exp_done: 5};
    vecs[2] = '{rel:  0,   half: 0, dly: 7, exp_pos: 0,   exp_phase: 0, exp_coils: 4'b1000, exp_done: 1};
    vecs[3] = '{rel: -128, half: 1, dly: 1, exp_pos: 128, exp_phase: 0, exp_coils: 4'b1000, exp_done: 257};
    vecs[4] = '{rel:  1,   half: 1, dly: 3, exp_pos: 1,   exp_phase: 1, exp_coils: 4'b1100, exp_done: 5};
    vecs[5] = '{rel: -1,   half: 0, dly: 2, exp_pos: 255, exp_phase: 6, exp_coils: 4'b0001, exp_done: 4};

    @(negedge clk);
    do_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step_pulse", 32'(step_pulse), 32'd0);
    chk("rst_position", 32'($unsigned(position)), 32'd0);
    chk("rst_coils", 32'(coils), 32'b1000);

    foreach (vecs[i]) begin
      do_reset();
      run_cmd(vecs[i].rel, vecs[i].half, vecs[i].dly, 1'b0, ds);
      chk("vec_done_cycle", 32'(ds), 32'(vecs[i].exp_done));
      chk("vec_position", 32'($unsigned(position)), 32'(vecs[i].exp_pos));
      chk("vec_phase", 32'(phase), 32'(vecs[i].exp_phase));
      chk("vec_coils", 32'(coils), 32'(vecs[i].exp_coils));
    end

    do_reset();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 7) == 0) rel = int'($urandom_range(0, 255)) - 128;
      else rel = int'($urandom_range(0, 40)) - 20;
      run_cmd(rel, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 1'b1, ds);
      repeat ($urandom_range(0, 2)) tick();
    end

    // abort during the second WAIT, with a stray command while busy
    do_reset();
    cmd_rel = 8'sd5; cmd_half = 1'b0; delay_cycles = 20'd4; cmd_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      cmd_valid = (c == 3);
      cmd_rel = (c == 3) ? 8'sd9 : 8'sd5;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    m_pos = 2; m_phase = 4;
    check_pos_model("abort");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_hold_pos", 32'($unsigned(position)), 32'd2);
    end
    run_cmd(3, 1'b0, 4, 1'b0, ds);
    chk("fresh_done_cycle", 32'(ds), 32'd16);
    chk("fresh_position", 32'($unsigned(position)), 32'd5);

    // abort coincident with a STEP cycle still applies that step
    cmd_rel = 8'sd2; cmd_half = 1'b1; delay_cycles = 20'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    m_pos = 6; m_phase = 3;
    check_pos_model("abort_step");
    chk("abort_step_ready", 32'(cmd_ready), 32'd1);
    chk("abort_step_done", 32'(done), 32'd0);

    // abort wins over cmd_valid in IDLE; abort alone in IDLE is harmless
    abort = 1'b1; cmd_valid = 1'b1; cmd_rel = 8'sd4;
    tick();
    chk("abort_prio_ready", 32'(cmd_ready), 32'd1);
    chk("abort_prio_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    tick();
    abort = 1'b0;
    run_cmd(1, 1'b0, 1, 1'b0, ds);
    chk("after_idle_abort_done", 32'(ds), 32'd3);

    // asynchronous reset between edges during WAIT
    cmd_rel = 8'sd5; cmd_half = 1'b0; delay_cycles = 20'd6; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_position", 32'($unsigned(position)), 32'd0);
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_coils", 32'(coils), 32'b1000);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_step_pulse", 32'(step_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_pos = 0; m_phase = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("arst_discarded_pulse", 32'(step_pulse), 32'd0);
      chk("arst_discarded_pos", 32'($unsigned(position)), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
